// File: rtl/spi_burst_bridge.sv
// spi_burst_bridge: decodes a command/address/length header from the SPI byte
// stream and issues 1..2^LEN_WIDTH auto-incrementing bus beats per frame.
// The bus address register survives frame boundaries so a host can keep
// streaming from where the previous frame stopped.
//
// state   | meaning
// --------+------------------------------------------------------------
// CMD     | waiting for the command byte of a frame
// ADDR    | shifting in ADDR_BYTES address bytes, MSB first
// LEN     | waiting for the burst length byte
// XFER    | write: waiting for a data byte; read: issue the beat now
// BUSY    | bus request outstanding, waiting for bus_ready_i
// RD_WAIT | read data on tx_byte_o, waiting for the host dummy byte
// DONE    | burst complete, ignoring bytes until chip select rises
module spi_burst_bridge #(
    parameter int ADDR_WIDTH = 17,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk_sys_i,
    input  logic                  reset_ni,
    input  logic                  spi_cs_ni,
    input  logic [7:0]            rx_byte_i,
    input  logic                  rx_valid_i,
    output logic [7:0]            tx_byte_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [7:0]            bus_data_o,
    input  logic [7:0]            bus_data_i,
    output logic                  bus_rw_no,
    output logic                  bus_valid_o,
    input  logic                  bus_ready_i,
    output logic                  done_o,
    output logic                  overrun_o,
    output logic [3:0]            state_o
);

    localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
    localparam int CNT_WIDTH  = LEN_WIDTH + 1;
    localparam logic [1:0] LAST_ABYTE = 2'(ADDR_BYTES - 1);

    typedef enum logic [3:0] {
        S_CMD     = 4'd0,
        S_ADDR    = 4'd1,
        S_LEN     = 4'd2,
        S_XFER    = 4'd3,
        S_BUSY    = 4'd4,
        S_RD_WAIT = 4'd5,
        S_DONE    = 4'd6
    } state_t;

    state_t                 state, state_n;
    logic                   cmd_rw, cmd_rw_n;
    logic                   cmd_burst, cmd_burst_n;
    logic [1:0]             abyte_cnt, abyte_cnt_n;
    logic [CNT_WIDTH-1:0]   count, count_n;
    logic [CNT_WIDTH-1:0]   count_dec;
    logic                   cs_q;
    logic [ADDR_WIDTH-1:0]  addr_n;
    logic [ADDR_WIDTH-1:0]  addr_shift;
    logic [7:0]             data_n;
    logic [7:0]             tx_n;
    logic                   rw_n;
    logic                   valid_n;
    logic                   done_n;
    logic                   overrun_n;

    // Address bytes enter at the bottom; bits pushed above ADDR_WIDTH fall off,
    // which is how unused high bits of the first header byte get ignored.
    assign addr_shift = ADDR_WIDTH'({bus_addr_o, rx_byte_i});
    assign count_dec  = count - CNT_WIDTH'(1);
    assign state_o    = state;

    // Next-state and datapath decode; every register holds unless an event moves it.
    always_comb begin
        state_n     = state;
        cmd_rw_n    = cmd_rw;
        cmd_burst_n = cmd_burst;
        abyte_cnt_n = abyte_cnt;
        count_n     = count;
        addr_n      = bus_addr_o;
        data_n      = bus_data_o;
        tx_n        = tx_byte_o;
        rw_n        = bus_rw_no;
        valid_n     = bus_valid_o;
        done_n      = 1'b0;
        overrun_n   = overrun_o;

        if (cs_q && !spi_cs_ni) begin
            overrun_n = 1'b0;
        end

        case (state)
            S_CMD: begin
                if (!spi_cs_ni && rx_valid_i) begin
                    cmd_rw_n    = rx_byte_i[7];
                    cmd_burst_n = rx_byte_i[5];
                    count_n     = CNT_WIDTH'(1);
                    abyte_cnt_n = 2'd0;
                    if (rx_byte_i[6]) begin
                        state_n = S_ADDR;
                    end else if (rx_byte_i[5]) begin
                        state_n = S_LEN;
                    end else begin
                        state_n = S_XFER;
                    end
                end
            end
            S_ADDR: begin
                if (spi_cs_ni) begin
                    state_n = S_CMD;
                end else if (rx_valid_i) begin
                    addr_n      = addr_shift;
                    abyte_cnt_n = abyte_cnt + 2'd1;
                    if (abyte_cnt == LAST_ABYTE) begin
                        state_n = cmd_burst ? S_LEN : S_XFER;
                    end
                end
            end
            S_LEN: begin
                if (spi_cs_ni) begin
                    state_n = S_CMD;
                end else if (rx_valid_i) begin
                    count_n = CNT_WIDTH'(rx_byte_i[LEN_WIDTH-1:0]) + CNT_WIDTH'(1);
                    state_n = S_XFER;
                end
            end
            S_XFER: begin
                if (spi_cs_ni) begin
                    state_n = S_CMD;
                end else if (cmd_rw) begin
                    valid_n = 1'b1;
                    rw_n    = 1'b1;
                    state_n = S_BUSY;
                end else if (rx_valid_i) begin
                    data_n  = rx_byte_i;
                    valid_n = 1'b1;
                    rw_n    = 1'b0;
                    state_n = S_BUSY;
                end
            end
            S_BUSY: begin
                // A byte landing here has nowhere to go; flag it and drop it.
                if (rx_valid_i) begin
                    overrun_n = 1'b1;
                end
                // Chip select is only honoured once the pending beat retires.
                if (bus_ready_i) begin
                    valid_n = 1'b0;
                    addr_n  = bus_addr_o + ADDR_WIDTH'(1);
                    count_n = count_dec;
                    if (cmd_rw) begin
                        tx_n = bus_data_i;
                    end
                    if (count_dec == '0) begin
                        done_n = 1'b1;
                    end
                    if (spi_cs_ni) begin
                        state_n = S_CMD;
                    end else if (count_dec == '0) begin
                        state_n = S_DONE;
                    end else if (cmd_rw) begin
                        state_n = S_RD_WAIT;
                    end else begin
                        state_n = S_XFER;
                    end
                end
            end
            S_RD_WAIT: begin
                if (spi_cs_ni) begin
                    state_n = S_CMD;
                end else if (rx_valid_i) begin
                    valid_n = 1'b1;
                    rw_n    = 1'b1;
                    state_n = S_BUSY;
                end
            end
            S_DONE: begin
                if (spi_cs_ni) begin
                    state_n = S_CMD;
                end
            end
            default: begin
                state_n = S_CMD;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_sys_i) begin
        if (!reset_ni) begin
            state       <= S_CMD;
            cmd_rw      <= 1'b1;
            cmd_burst   <= 1'b0;
            abyte_cnt   <= 2'd0;
            count       <= '0;
            cs_q        <= 1'b1;
            bus_addr_o  <= '0;
            bus_data_o  <= 8'h00;
            tx_byte_o   <= 8'h00;
            bus_rw_no   <= 1'b1;
            bus_valid_o <= 1'b0;
            done_o      <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            state       <= state_n;
            cmd_rw      <= cmd_rw_n;
            cmd_burst   <= cmd_burst_n;
            abyte_cnt   <= abyte_cnt_n;
            count       <= count_n;
            cs_q        <= spi_cs_ni;
            bus_addr_o  <= addr_n;
            bus_data_o  <= data_n;
            tx_byte_o   <= tx_n;
            bus_rw_no   <= rw_n;
            bus_valid_o <= valid_n;
            done_o      <= done_n;
            overrun_o   <= overrun_n;
        end
    end

endmodule

// File: tb/tb_spi_burst_bridge.sv
// Directed bench for spi_burst_bridge: a table of single-beat frames plus
// hand-written sequences for bursts, streaming, wrap, overrun/abort and reset.
module tb_spi_burst_bridge;

    localparam logic [3:0] S_CMD     = 4'd0;
    localparam logic [3:0] S_BUSY    = 4'd4;
    localparam logic [3:0] S_RD_WAIT = 4'd5;
    localparam logic [3:0] S_DONE    = 4'd6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs_n;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  tx_byte;
    logic [16:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_rw_n;
    logic        bus_valid;
    logic        bus_ready;
    logic        done;
    logic        overrun;
    logic [3:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    spi_burst_bridge #(.ADDR_WIDTH(17), .LEN_WIDTH(8)) dut (
        .clk_sys_i  (clk),
        .reset_ni   (rst_n),
        .spi_cs_ni  (cs_n),
        .rx_byte_i  (rx_byte),
        .rx_valid_i (rx_valid),
        .tx_byte_o  (tx_byte),
        .bus_addr_o (bus_addr),
        .bus_data_o (bus_wdata),
        .bus_data_i (bus_rdata),
        .bus_rw_no  (bus_rw_n),
        .bus_valid_o(bus_valid),
        .bus_ready_i(bus_ready),
        .done_o     (done),
        .overrun_o  (overrun),
        .state_o    (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [23:0] abytes;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          dly;
        logic [16:0] exp_addr;
        logic [16:0] exp_next;
        logic [7:0]  exp_tx;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        step();
    endtask

    task automatic frame_end();
        cs_n = 1'b1;
        step();
        chk("frame_end_state", 32'(dbg_state), 32'(S_CMD));
    endtask

    // Wait for a request, check it, hold ready low for dly-1 cycles, then accept it.
    task automatic beat(input logic exp_rw, input logic [16:0] exp_addr,
                        input logic [7:0] exp_data, input logic [7:0] rd,
                        input int dly, input logic exp_done);
        int t;
        int bad;
        logic [16:0] nxt;
        t = 0;
        while (!bus_valid && t < 20) begin
            step();
            t++;
        end
        if (!bus_valid) begin
            chk("beat_timeout", 32'(bus_valid), 32'(1));
            return;
        end
        chk("beat_addr", 32'(bus_addr), 32'(exp_addr));
        chk("beat_rw", 32'(bus_rw_n), 32'(exp_rw));
        if (!exp_rw) chk("beat_wdata", 32'(bus_wdata), 32'(exp_data));
        bad = 0;
        for (int i = 1; i < dly; i++) begin
            step();
            if (!bus_valid || bus_addr !== exp_addr || bus_wdata !== exp_data && !exp_rw) bad++;
        end
        chk("beat_hold", 32'(bad), 32'(0));
        bus_ready = 1'b1;
        bus_rdata = rd;
        step();
        bus_ready = 1'b0;
        bus_rdata = 8'h00;
        nxt = exp_addr + 17'd1;
        chk("beat_valid_drop", 32'(bus_valid), 32'(0));
        chk("beat_done", 32'(done), 32'(exp_done));
        chk("beat_addr_inc", 32'(bus_addr), 32'(nxt));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 24'h012345, 8'hA5, 8'h00, 3, 17'h12345, 17'h12346, 8'h00};
        vecs[1] = '{1'b0, 24'hFE1FFF, 8'h3C, 8'h00, 1, 17'h01FFF, 17'h02000, 8'h00};
        vecs[2] = '{1'b1, 24'h00ABCD, 8'h00, 8'h5A, 2, 17'h0ABCD, 17'h0ABCE, 8'h5A};
        vecs[3] = '{1'b1, 24'h01FFFF, 8'h00, 8'hC3, 1, 17'h1FFFF, 17'h00000, 8'hC3};
        vecs[4] = '{1'b0, 24'h000000, 8'hFF, 8'h00, 4, 17'h00000, 17'h00001, 8'hC3};

        rst_n = 1'b0; cs_n = 1'b1; rx_byte = 8'h00; rx_valid = 1'b0;
        bus_rdata = 8'h00; bus_ready = 1'b0;
        step(); step(); step();
        chk("rst_state", 32'(dbg_state), 32'(S_CMD));
        chk("rst_addr", 32'(bus_addr), 32'(0));
        chk("rst_wdata", 32'(bus_wdata), 32'(0));
        chk("rst_tx", 32'(tx_byte), 32'(0));
        chk("rst_rw", 32'(bus_rw_n), 32'(1));
        chk("rst_valid", 32'(bus_valid), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_overrun", 32'(overrun), 32'(0));
        rst_n = 1'b1;
        step();

        // Chip select rising together with bus_ready: beat counted, no done.
        frame_start();
        send_byte(8'h20);
        send_byte(8'h01);
        send_byte(8'h12);
        chk("sim_valid", 32'(bus_valid), 32'(1));
        cs_n = 1'b1; bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        chk("sim_addr", 32'(bus_addr), 32'(1));
        chk("sim_state", 32'(dbg_state), 32'(S_CMD));
        chk("sim_done", 32'(done), 32'(0));
        chk("sim_valid_drop", 32'(bus_valid), 32'(0));
        step();

        for (int i = 0; i < 5; i++) begin
            frame_start();
            send_byte(vecs[i].rw ? 8'hC0 : 8'h40);
            send_byte(vecs[i].abytes[23:16]);
            send_byte(vecs[i].abytes[15:8]);
            send_byte(vecs[i].abytes[7:0]);
            if (!vecs[i].rw) send_byte(vecs[i].wdata);
            beat(vecs[i].rw, vecs[i].exp_addr, vecs[i].wdata, vecs[i].rdata, vecs[i].dly, 1'b1);
            chk("vec_state_done", 32'(dbg_state), 32'(S_DONE));
            frame_end();
            chk("vec_addr_kept", 32'(bus_addr), 32'(vecs[i].exp_next));
            chk("vec_tx_kept", 32'(tx_byte), 32'(vecs[i].exp_tx));
        end

        // Burst read of four beats, read data = low address byte.
        frame_start();
        send_byte(8'hE0); send_byte(8'h00); send_byte(8'h80); send_byte(8'h00);
        send_byte(8'h03);
        for (int n = 0; n < 4; n++) begin
            beat(1'b1, 17'h08000 + 17'(n), 8'h00, 8'(n), 1, (n == 3));
            chk("burst_tx", 32'(tx_byte), 32'(n));
            if (n < 3) begin
                chk("burst_rd_wait", 32'(dbg_state), 32'(S_RD_WAIT));
                send_byte(8'h00);
            end
        end
        chk("burst_state_done", 32'(dbg_state), 32'(S_DONE));
        step();
        chk("burst_done_pulse", 32'(done), 32'(0));
        send_byte(8'h5A);
        chk("done_ignores_rx_state", 32'(dbg_state), 32'(S_DONE));
        chk("done_ignores_rx_valid", 32'(bus_valid), 32'(0));
        frame_end();

        // Streaming writes from the persisted address.
        frame_start();
        send_byte(8'h20); send_byte(8'h01); send_byte(8'h11);
        beat(1'b0, 17'h08004, 8'h11, 8'h00, 2, 1'b0);
        send_byte(8'h22);
        beat(1'b0, 17'h08005, 8'h22, 8'h00, 1, 1'b1);
        frame_end();
        chk("stream_addr", 32'(bus_addr), 32'(17'h08006));

        // Address wrap at the top of the 17-bit space.
        frame_start();
        send_byte(8'h60); send_byte(8'h01); send_byte(8'hFF); send_byte(8'hFF);
        send_byte(8'h01); send_byte(8'h77);
        beat(1'b0, 17'h1FFFF, 8'h77, 8'h00, 1, 1'b0);
        send_byte(8'h88);
        beat(1'b0, 17'h00000, 8'h88, 8'h00, 1, 1'b1);
        frame_end();

        // Overrun during a held beat, then abort mid-burst.
        frame_start();
        send_byte(8'h60); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'h02); send_byte(8'h99);
        send_byte(8'h55);
        chk("ovr_flag", 32'(overrun), 32'(1));
        chk("ovr_state", 32'(dbg_state), 32'(S_BUSY));
        beat(1'b0, 17'h00010, 8'h99, 8'h00, 2, 1'b0);
        send_byte(8'h66);
        chk("abort_valid", 32'(bus_valid), 32'(1));
        cs_n = 1'b1;
        step(); step();
        chk("abort_hold_state", 32'(dbg_state), 32'(S_BUSY));
        chk("abort_hold_valid", 32'(bus_valid), 32'(1));
        chk("abort_hold_data", 32'(bus_wdata), 32'(8'h66));
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        chk("abort_valid_drop", 32'(bus_valid), 32'(0));
        chk("abort_state", 32'(dbg_state), 32'(S_CMD));
        chk("abort_addr", 32'(bus_addr), 32'(17'h00012));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_ovr_sticky", 32'(overrun), 32'(1));
        step();
        chk("abort_no_reissue", 32'(bus_valid), 32'(0));
        cs_n = 1'b0;
        step();
        chk("ovr_clear_on_start", 32'(overrun), 32'(0));
        frame_end();

        // Reset while a write beat is pending.
        frame_start();
        send_byte(8'h40); send_byte(8'h00); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB);
        chk("rstb_valid_before", 32'(bus_valid), 32'(1));
        rst_n = 1'b0;
        step();
        chk("rstb_valid", 32'(bus_valid), 32'(0));
        chk("rstb_addr", 32'(bus_addr), 32'(0));
        chk("rstb_state", 32'(dbg_state), 32'(S_CMD));
        chk("rstb_wdata", 32'(bus_wdata), 32'(0));
        chk("rstb_rw", 32'(bus_rw_n), 32'(1));
        rst_n = 1'b1;
        cs_n  = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_burst_bridge.md
Name: spi_burst_bridge

Overview:
Parametrised successor of the single-transfer SPI-to-bus bridge. Consumes the byte stream from the spi_byte deserializer and decodes command, address and length headers. It then issues 1..MAX_BURST auto-incrementing bus reads or writes per chip-select frame. The address register persists across frames, so a host can stream without resending the address. Sits between spi_byte and the system bus arbiter, in the clk_sys_i domain.

Parameters:
ADDR_WIDTH, 17, bus address width (1..24); ADDR_BYTES = ceil(ADDR_WIDTH/8) header bytes, sent MSB first; unused high bits ignored.
LEN_WIDTH, 8, length field width (1..8); burst count = LEN+1, so MAX_BURST = 2^LEN_WIDTH.

Ports:
clk_sys_i  in  1  system clock; all logic on rising edge
reset_ni  in  1  synchronous active-low reset
spi_cs_ni  in  1  chip select, already synchronised to clk_sys_i; high = frame idle
rx_byte_i  in  8  received byte from spi_byte
rx_valid_i  in  1  one-cycle strobe, rx_byte_i valid
tx_byte_o  out  8  byte shifted out during the next SPI byte
bus_addr_o  out  ADDR_WIDTH  bus address
bus_data_o  out  8  write data
bus_data_i  in  8  read data, sampled when bus_ready_i=1
bus_rw_no  out  1  1 = read, 0 = write
bus_valid_o  out  1  request; held until bus_ready_i
bus_ready_i  in  1  request accepted/completed this cycle
done_o  out  1  one-cycle pulse when the last beat of a burst completes
overrun_o  out  1  sticky; a data byte arrived while a bus beat was pending
state_o  out  4  FSM state, for debug

Behaviour:
- Reset (reset_ni=0 at clock edge): state=CMD, bus_addr_o=0, bus_data_o=0, tx_byte_o=0, bus_rw_no=1, bus_valid_o=0, done_o=0, overrun_o=0, count=0.
- Command byte: [7]=rw_n, [6]=load address, [5]=burst (length byte follows), [4:0] ignored. Non-burst count=1.
- States: CMD -> ADDR (if [6], ADDR_BYTES bytes) -> LEN (if [5]) -> XFER.
- Bytes are accepted only on rx_valid_i; header shifting never stalls.
- Write path: XFER waits for a data byte. On rx_valid_i: bus_data_o<=rx_byte_i, bus_valid_o=1, bus_rw_no=0, go to BUSY.
- Read path: on entering XFER, immediately assert bus_valid_o with bus_rw_no=1 and go to BUSY.
- BUSY: hold bus_valid_o, bus_addr_o and bus_data_o stable until bus_ready_i=1. In that cycle:
  - drop bus_valid_o next cycle;
  - bus_addr_o <= bus_addr_o+1, wrapping modulo 2^ADDR_WIDTH;
  - count decrements;
  - on a read, tx_byte_o<=bus_data_i.
- After BUSY, if count==0: pulse done_o and go to DONE. Otherwise:
  - write goes to XFER;
  - read goes to RD_WAIT, which waits for rx_valid_i (host dummy byte that shifted tx_byte_o out), then issues the next read.
- Read prefetch: beat n's data is on tx_byte_o before the byte following the header (n=0) or following dummy byte n-1. The host must leave one bus latency of gap per byte.
- Overrun: rx_valid_i while in BUSY sets overrun_o. The byte is dropped, not counted and does not change bus_data_o.
- DONE: ignore further rx_valid_i until the frame ends.
- Frame end: spi_cs_ni=1 in any state except BUSY returns to CMD next clock. In BUSY, the pending beat completes first, then returns to CMD; no further beats are issued.
- Frame end preserves bus_addr_o and tx_byte_o.
- Frame start: the first clock with spi_cs_ni=0 after a high period clears overrun_o.
- Simultaneous events: if bus_ready_i and spi_cs_ni rise together, the beat is counted and the address incremented; no done_o unless count reaches 0.
- If rx_valid_i and bus_ready_i coincide in BUSY, overrun is flagged (the beat is still completing).
- Reset has priority over all events, including mid-burst and mid-handshake; bus_valid_o drops on the next edge.

Test Plan:
- Single write: cmd 0x40, addr 0x01,0x23,0x45, data 0xA5, bus_ready_i after 3 clocks -> one write at 0x12345 with 0xA5, valid held 3 clocks, done_o pulse, bus_addr_o=0x12346.
- Burst read: cmd 0xE0, addr 0x00,0x80,0x00, len 0x03, bus_data_i=addr[7:0] -> reads at 0x08000..0x08003; tx_byte_o sequence 0x00,0x01,0x02,0x03; exactly one done_o.
- Streaming without address: after the previous test, new frame cmd 0x20, len 0x01, data 0x11,0x22 -> writes 0x08004=0x11 and 0x08005=0x22.
- Wrap: load address 0x1FFFF, burst write of 2 -> writes at 0x1FFFF then 0x00000.
- Overrun/abort: hold bus_ready_i low during a write beat and send a second data byte -> overrun_o=1 and the byte is dropped. Raising spi_cs_ni mid-burst -> pending beat completes, FSM returns to CMD, overrun_o clears on the next frame start.
- Reset mid-BUSY: reset_ni=0 while bus_valid_o=1 -> next edge bus_valid_o=0, bus_addr_o=0, state_o=CMD.
